// File: rtl/wb_arbiter.sv
// wb_arbiter: register file write-port owner. Arbitrates between the ALU
// result path and a buffered long-latency (load/mul) result queue, and keeps
// a pending-destination scoreboard for decode stalls.
// Optional feature: define WB_FAIR_EN to enable the queue starvation guard.
module wb_arbiter #(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [4:0]        iss_rd,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_rd,
    input  logic [DWIDTH-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [4:0]        lsu_rd,
    input  logic [DWIDTH-1:0] lsu_data,
    output logic              we,
    output logic [4:0]        rdst_id,
    output logic [DWIDTH-1:0] rdst,
    output logic [31:0]       pend
);

    localparam int unsigned RW = 5;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Elaboration-time parameter sanity checks
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("wb_arbiter: DEPTH must be a power of two >= 2");
    end
    if (STARVE_MAX < 1) begin : g_starve_chk
        $error("wb_arbiter: STARVE_MAX must be >= 1");
    end

    typedef struct packed {
        logic [RW-1:0]     rd;
        logic [DWIDTH-1:0] data;
    } wb_entry_t;

    wb_entry_t     q_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    wb_entry_t     head_c;
    logic          q_empty_c;
    logic          push_c;
    logic          pop_c;
    logic          alu_win_c;
    logic [31:0]   pend_next_c;

    assign head_c    = q_mem[rd_ptr];
    assign q_empty_c = (count == '0);
    assign lsu_ready = (count != CW'(DEPTH));
    assign push_c    = lsu_valid && lsu_ready;
    assign alu_win_c = alu_valid && alu_ready;
    assign pop_c     = !alu_win_c && !q_empty_c;

`ifdef WB_FAIR_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;

    // Queue wins unconditionally once it has lost STARVE_MAX times in a row
    assign alu_ready = !((starve_cnt == SW'(STARVE_MAX)) && !q_empty_c);

    // Count consecutive arbitrations the non-empty queue loses to the ALU
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (pop_c || q_empty_c) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    assign alu_ready = 1'b1;
`endif

    // Queue storage; contents are don't-care while their slot is empty
    always_ff @(posedge clk) begin
        if (push_c) begin
            q_mem[wr_ptr] <= '{rd: lsu_rd, data: lsu_data};
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Scoreboard update: pop clears, issue sets, set wins on collision
    always_comb begin
        pend_next_c = pend;
        if (pop_c && head_c.rd != '0) begin
            pend_next_c[head_c.rd] = 1'b0;
        end
        if (iss_valid && iss_rd != '0) begin
            pend_next_c[iss_rd] = 1'b1;
        end
        pend_next_c[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next_c;
        end
    end

    // Register file write port; writes to x0 are swallowed
    always_ff @(posedge clk) begin
        if (rst) begin
            we      <= 1'b0;
            rdst_id <= '0;
            rdst    <= '0;
        end else begin
            we <= 1'b0;
            if (alu_win_c) begin
                if (alu_rd != '0) begin
                    we      <= 1'b1;
                    rdst_id <= alu_rd;
                    rdst    <= alu_data;
                end
            end else if (pop_c) begin
                if (head_c.rd != '0) begin
                    we      <= 1'b1;
                    rdst_id <= head_c.rd;
                    rdst    <= head_c.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue/scoreboard reference model plus
// directed scenarios with literal expectations.
module tb_wb_arbiter;

    localparam int DWIDTH     = 32;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;
`ifdef WB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              iss_valid;
    logic [4:0]        iss_rd;
    logic              alu_valid;
    logic              alu_ready;
    logic [4:0]        alu_rd;
    logic [DWIDTH-1:0] alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [4:0]        lsu_rd;
    logic [DWIDTH-1:0] lsu_data;
    logic              we;
    logic [4:0]        rdst_id;
    logic [DWIDTH-1:0] rdst;
    logic [31:0]       pend;

    wb_arbiter #(
        .DWIDTH    (DWIDTH),
        .DEPTH     (DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_rd   (lsu_rd),
        .lsu_data (lsu_data),
        .we       (we),
        .rdst_id  (rdst_id),
        .rdst     (rdst),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO of pending results, set of outstanding registers
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_e;
    logic [31:0] m_pend;
    logic [31:0] m_nxt;
    bit          m_we;
    logic [4:0]  m_id;
    logic [31:0] m_data;
    bit          m_alu_ready;
    bit          m_full;
    int          losses;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_pend      = '0;
            m_we        = 1'b0;
            m_id        = '0;
            m_data      = '0;
            losses      = 0;
            m_alu_ready = 1'b1;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_nxt  = m_pend;
            m_we   = 1'b0;
            if (alu_valid && m_alu_ready) begin
                if (alu_rd != 0) begin
                    m_we   = 1'b1;
                    m_id   = alu_rd;
                    m_data = alu_data;
                end
                losses = (mq.size() != 0) ? losses + 1 : 0;
            end else if (mq.size() != 0) begin
                m_e = mq.pop_front();
                if (m_e.rd != 0) begin
                    m_we          = 1'b1;
                    m_id          = m_e.rd;
                    m_data        = m_e.data;
                    m_nxt[m_e.rd] = 1'b0;
                end
                losses = 0;
            end else begin
                losses = 0;
            end
            if (iss_valid && iss_rd != 0) m_nxt[iss_rd] = 1'b1;
            if (lsu_valid && !m_full) mq.push_back('{rd: lsu_rd, data: lsu_data});
            m_pend      = m_nxt;
            m_alu_ready = !(FAIR && losses == STARVE_MAX && mq.size() != 0);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_alu_ready", 64'(alu_ready), 64'(m_alu_ready));
            chk("m_lsu_ready", 64'(lsu_ready), 64'(mq.size() != DEPTH));
            chk("m_we", 64'(we), 64'(m_we));
            chk("m_rdst_id", 64'(rdst_id), 64'(m_id));
            chk("m_rdst", 64'(rdst), 64'(m_data));
            chk("m_pend", 64'(pend), 64'(m_pend));
        end
    end

    initial begin
        rst       = 1'b1;
        iss_valid = 1'b0;
        iss_rd    = '0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;
        step();
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        chk("alu_we", 64'(we), 64'd1);
        chk("alu_id", 64'(rdst_id), 64'd5);
        chk("alu_data", 64'(rdst), 64'hDEADBEEF);
        step();
        chk("alu_we_pulse", 64'(we), 64'd0);

        // Scoreboard: issue rd7, result three cycles later
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0;
        chk("sb_pend7_set", 64'(pend[7]), 64'd1);
        step();
        step();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h12;
        step();
        lsu_valid = 1'b0;
        chk("sb_pend7_wait", 64'(pend[7]), 64'd1);
        chk("sb_no_passthru", 64'(we), 64'd0);
        step();
        chk("sb_we", 64'(we), 64'd1);
        chk("sb_id", 64'(rdst_id), 64'd7);
        chk("sb_data", 64'(rdst), 64'h12);
        chk("sb_pend7_clr", 64'(pend[7]), 64'd0);

        // Re-issue of rd7 on the pop edge keeps it pending
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h34;
        step();
        lsu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0;
        chk("sb_reiss_we", 64'(we), 64'd1);
        chk("sb_reiss_data", 64'(rdst), 64'h34);
        chk("sb_reiss_pend7", 64'(pend[7]), 64'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h56;
        step();
        lsu_valid = 1'b0;
        step();
        chk("sb_final_pend7", 64'(pend[7]), 64'd0);

        // Full queue under continuous ALU traffic, then FIFO drain
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_rd   = 5'(1 + i);
            alu_data = 32'(100 + i);
            lsu_rd   = 5'(10 + i);
            lsu_data = 32'hA000 + 32'(i);
            step();
`ifndef WB_FAIR_EN
            chk("fill_alu_id", 64'(rdst_id), 64'(1 + i));
`endif
        end
`ifndef WB_FAIR_EN
        chk("full_lsu_ready", 64'(lsu_ready), 64'd0);
        lsu_rd = 5'd14; lsu_data = 32'hBAD; alu_rd = 5'd9; alu_data = 32'h99;
        step();
        chk("full_alu_id", 64'(rdst_id), 64'd9);
        chk("full_still", 64'(lsu_ready), 64'd0);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_we", 64'(we), 64'd1);
            chk("drain_id", 64'(rdst_id), 64'(10 + i));
            chk("drain_data", 64'(rdst), 64'(32'hA000 + 32'(i)));
        end
        step();
        chk("drain_done_we", 64'(we), 64'd0);
        chk("drain_lsu_ready", 64'(lsu_ready), 64'd1);
`else
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        repeat (6) step();
`endif

        // Reset while the queue is full and registers are pending
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h3;
        iss_valid = 1'b1; iss_rd = 5'd3;
        repeat (4) step();
        alu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_we", 64'(we), 64'd0);
        chk("rr_pend", 64'(pend), 64'd0);
        chk("rr_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("rr_alu_ready", 64'(alu_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rr_no_stale", 64'(we), 64'd0);
        end

        // Starvation: one queued entry against continuous ALU traffic
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h101;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h55;
        step();
        lsu_valid = 1'b0;
        chk("st_first", 64'(rdst_id), 64'd1);
`ifdef WB_FAIR_EN
        for (int i = 0; i < 3; i++) begin
            alu_rd   = 5'(2 + i);
            alu_data = 32'h100 + 32'(2 + i);
            step();
            chk("st_alu_id", 64'(rdst_id), 64'(2 + i));
        end
        chk("st_forced", 64'(alu_ready), 64'd0);
        alu_rd = 5'd5; alu_data = 32'h105;
        step();
        chk("st_q_id", 64'(rdst_id), 64'd20);
        chk("st_q_data", 64'(rdst), 64'h55);
        chk("st_resume_rdy", 64'(alu_ready), 64'd1);
        step();
        chk("st_resume_id", 64'(rdst_id), 64'd5);
        alu_valid = 1'b0;
`else
        for (int i = 0; i < 4; i++) begin
            alu_rd   = 5'(2 + i);
            alu_data = 32'h100 + 32'(2 + i);
            step();
            chk("st_alu_id", 64'(rdst_id), 64'(2 + i));
        end
        alu_valid = 1'b0;
        step();
        chk("st_q_id", 64'(rdst_id), 64'd20);
        chk("st_q_data", 64'(rdst), 64'h55);
`endif
        step();

        // Destination x0 on both paths
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        step();
        alu_rd = 5'd0; alu_data = 32'hFFFF;
        step();
        alu_valid = 1'b0;
        chk("x0_alu_we", 64'(we), 64'd0);
        chk("x0_alu_hold_id", 64'(rdst_id), 64'd9);
        chk("x0_alu_hold_data", 64'(rdst), 64'h99);
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h77;
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        lsu_valid = 1'b0; iss_valid = 1'b0;
        chk("x0_pend0", 64'(pend[0]), 64'd0);
        step();
        chk("x0_lsu_we", 64'(we), 64'd0);
        chk("x0_lsu_hold_id", 64'(rdst_id), 64'd9);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
